// File: rtl/board_state_server.sv
// board_state_server
//   Game-state responder behind the VGA controller's board interface. Holds
//   the 5x5 minesweeper status array, serves per-pixel display reads, and
//   resolves cursor reveals into neighbour-mine counts or a mine hit, while
//   tracking win/lose.
//
//   Status codes: 0-8 revealed count, 9 revealed mine, 10 hidden, 11 flagged.
//
//   Optional feature macro: BOARD_FLAG_EN (adds the flagReq input that toggles
//   a hidden cell to flagged and back).
//
// Ports
//   clk            system clock
//   reset          synchronous active-low reset
//   newGame        synchronous clear/restart, level-sampled
//   mineMap        bit i = mine at cell i, captured on reset/newGame
//   loadBlock      display read address (cell index)
//   memDataOut2    {28'b0, status}, registered one cycle after loadBlock
//   VGAid          cursor cell index for reveal/flag
//   pressed        reveal request level, held until acknowledged
//   flagReq        flag toggle request (BOARD_FLAG_EN only)
//   pr_reset       one-cycle acknowledge of a request
//   gameOver       a mine was revealed (sticky)
//   gameWon        all safe cells revealed (sticky)
//   revealedCount  number of safe cells revealed
module board_state_server #(
    parameter int GRID_W = 5,
    parameter int GRID_H = 5,
    parameter int CELLS  = GRID_W * GRID_H
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             newGame,
    input  logic [CELLS-1:0] mineMap,
    input  logic [31:0]      loadBlock,
    output logic [31:0]      memDataOut2,
    input  logic [31:0]      VGAid,
    input  logic             pressed,
`ifdef BOARD_FLAG_EN
    input  logic             flagReq,
`endif
    output logic             pr_reset,
    output logic             gameOver,
    output logic             gameWon,
    output logic [4:0]       revealedCount
);

    localparam int IW = $clog2(CELLS);

    localparam logic [3:0] ST_MINE   = 4'd9;
    localparam logic [3:0] ST_HIDDEN = 4'd10;
    localparam logic [3:0] ST_FLAG   = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_COUNT,
        S_WRITE,
        S_LOSE_SCAN,
        S_ACK,
        S_WAIT_LOW
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       cells_q [CELLS];
    logic [CELLS-1:0] mine_q;
    logic [4:0]       safe_q;          // CELLS - popcount(mineMap)
    logic [IW-1:0]    idx_q, idx_d;
    logic             oob_q, oob_d;    // latched VGAid was off the board
    logic [3:0]       cnt_q, cnt_d;
    logic [2:0]       nbr_q, nbr_d;
    logic [IW-1:0]    scan_q, scan_d;
    logic             over_q, over_d;
    logic             won_q, won_d;
    logic [4:0]       rev_q, rev_d;
    logic [3:0]       rd_q, rd_d;

    // single cell write port shared by every FSM state
    logic             cell_we;
    logic [IW-1:0]    cell_wa;
    logic [3:0]       cell_wd;

    logic             flag_req;

`ifdef BOARD_FLAG_EN
    assign flag_req = flagReq;
`else
    assign flag_req = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Neighbour addressing for the COUNT walk: nbr_q selects one of the
    // eight (dy,dx) offsets; anything falling off the grid (including the
    // column that would wrap to the next row) contributes nothing.
    // ------------------------------------------------------------------
    int            row_i, col_i, dy_i, dx_i, nr_i, nc_i;
    logic          in_grid;
    logic [IW-1:0] nbr_idx;
    logic          nbr_mine;

    always_comb begin
        row_i = int'(idx_q) / GRID_W;
        col_i = int'(idx_q) % GRID_W;
        dy_i  = 0;
        dx_i  = 0;
        case (nbr_q)
            3'd0: begin dy_i = -1; dx_i = -1; end
            3'd1: begin dy_i = -1; dx_i =  0; end
            3'd2: begin dy_i = -1; dx_i =  1; end
            3'd3: begin dy_i =  0; dx_i = -1; end
            3'd4: begin dy_i =  0; dx_i =  1; end
            3'd5: begin dy_i =  1; dx_i = -1; end
            3'd6: begin dy_i =  1; dx_i =  0; end
            default: begin dy_i = 1; dx_i = 1; end
        endcase
        nr_i     = row_i + dy_i;
        nc_i     = col_i + dx_i;
        in_grid  = (nr_i >= 0) && (nr_i < GRID_H) && (nc_i >= 0) && (nc_i < GRID_W);
        nbr_idx  = IW'(nr_i * GRID_W + nc_i);
        nbr_mine = in_grid ? mine_q[nbr_idx] : 1'b0;
    end

    // ------------------------------------------------------------------
    // Display read: sampled from the pre-write array, so a same-cycle
    // collision with an FSM write returns the old value.
    // ------------------------------------------------------------------
    always_comb begin
        rd_d = ST_HIDDEN;
        if (loadBlock < 32'(CELLS)) begin
            rd_d = cells_q[loadBlock[IW-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // Reveal / flag FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        oob_d   = oob_q;
        cnt_d   = cnt_q;
        nbr_d   = nbr_q;
        scan_d  = scan_q;
        over_d  = over_q;
        won_d   = won_q;
        rev_d   = rev_q;
        cell_we = 1'b0;
        cell_wa = idx_q;
        cell_wd = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (flag_req) begin
                    // flag takes priority over reveal; toggles hidden<->flagged only
                    if (VGAid < 32'(CELLS)) begin
                        cell_wa = VGAid[IW-1:0];
                        if (cells_q[VGAid[IW-1:0]] == ST_HIDDEN) begin
                            cell_we = 1'b1;
                            cell_wd = ST_FLAG;
                        end else if (cells_q[VGAid[IW-1:0]] == ST_FLAG) begin
                            cell_we = 1'b1;
                            cell_wd = ST_HIDDEN;
                        end
                    end
                    state_d = S_ACK;
                end else if (pressed) begin
                    idx_d   = VGAid[IW-1:0];
                    oob_d   = (VGAid >= 32'(CELLS));
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                cnt_d  = '0;
                nbr_d  = '0;
                scan_d = '0;
                if (oob_q || over_q || won_q || (cells_q[idx_q] != ST_HIDDEN)) begin
                    state_d = S_ACK;
                end else if (mine_q[idx_q]) begin
                    cell_we = 1'b1;
                    cell_wd = ST_MINE;
                    over_d  = 1'b1;
                    state_d = S_LOSE_SCAN;
                end else begin
                    state_d = S_COUNT;
                end
            end

            S_COUNT: begin
                cnt_d = cnt_q + {3'b000, nbr_mine};
                nbr_d = nbr_q + 3'd1;
                if (nbr_q == 3'd7) begin
                    state_d = S_WRITE;
                end
            end

            S_WRITE: begin
                cell_we = 1'b1;
                cell_wd = cnt_q;
                rev_d   = rev_q + 5'd1;
                if ((rev_q + 5'd1) == safe_q) begin
                    won_d = 1'b1;
                end
                state_d = S_ACK;
            end

            S_LOSE_SCAN: begin
                // uncover every mine on the board, one cell per cycle
                cell_wa = scan_q;
                cell_wd = ST_MINE;
                cell_we = mine_q[scan_q];
                scan_d  = scan_q + 1'b1;
                if (scan_q == IW'(CELLS - 1)) begin
                    state_d = S_ACK;
                end
            end

            S_ACK: begin
                state_d = S_WAIT_LOW;
            end

            S_WAIT_LOW: begin
                // a held request must drop before another can be taken
                if (!pressed && !flag_req) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset || newGame) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            oob_q   <= 1'b0;
            cnt_q   <= '0;
            nbr_q   <= '0;
            scan_q  <= '0;
            over_q  <= 1'b0;
            won_q   <= 1'b0;
            rev_q   <= '0;
            rd_q    <= ST_HIDDEN;
            mine_q  <= mineMap;
            safe_q  <= 5'(CELLS - $countones(mineMap));
            for (int i = 0; i < CELLS; i++) begin
                cells_q[i] <= ST_HIDDEN;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            oob_q   <= oob_d;
            cnt_q   <= cnt_d;
            nbr_q   <= nbr_d;
            scan_q  <= scan_d;
            over_q  <= over_d;
            won_q   <= won_d;
            rev_q   <= rev_d;
            rd_q    <= rd_d;
            if (cell_we) begin
                cells_q[cell_wa] <= cell_wd;
            end
        end
    end

    assign memDataOut2   = {28'b0, rd_q};
    assign pr_reset      = (state_q == S_ACK);
    assign gameOver      = over_q;
    assign gameWon       = won_q;
    assign revealedCount = rev_q;

endmodule

// File: tb/tb_board_state_server.sv
// Bench for board_state_server: random and directed reveals checked against
// an array-based game model (status per cell, neighbour counts by loops).
module tb_board_state_server;

    logic        clk = 1'b0;
    logic        reset, newGame, pressed;
    logic [24:0] mineMap;
    logic [31:0] loadBlock, VGAid;
    logic [31:0] memDataOut2;
    logic        pr_reset, gameOver, gameWon;
    logic [4:0]  revealedCount;
`ifdef BOARD_FLAG_EN
    logic        flagReq;
`endif

    int vectors = 0;
    int miscompares = 0;

    // game model
    int m_stat [25];
    bit m_mine [25];
    int m_rev, m_mines;
    bit m_over, m_won;

    always #5 clk = ~clk;

    board_state_server dut (
        .clk          (clk),
        .reset        (reset),
        .newGame      (newGame),
        .mineMap      (mineMap),
        .loadBlock    (loadBlock),
        .memDataOut2  (memDataOut2),
        .VGAid        (VGAid),
        .pressed      (pressed),
`ifdef BOARD_FLAG_EN
        .flagReq      (flagReq),
`endif
        .pr_reset     (pr_reset),
        .gameOver     (gameOver),
        .gameWon      (gameWon),
        .revealedCount(revealedCount)
    );

    function automatic void m_reset(input logic [24:0] map);
        m_rev = 0; m_over = 0; m_won = 0; m_mines = 0;
        for (int i = 0; i < 25; i++) begin
            m_stat[i] = 10;
            m_mine[i] = map[i];
            if (map[i]) m_mines++;
        end
    endfunction

    function automatic int m_nbr(input int idx);
        int r, c, n;
        r = idx / 5; c = idx % 5; n = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 5 &&
                    c + dc >= 0 && c + dc < 5 && m_mine[(r + dr) * 5 + c + dc])
                    n++;
        return n;
    endfunction

    function automatic bit m_ignored(input int idx);
        return (idx >= 25) || m_over || m_won || (m_stat[idx] != 10);
    endfunction

    // cycles from the press drive to the pr_reset pulse being visible
    function automatic int m_latency(input int idx);
        if (m_ignored(idx)) return 2;
        if (m_mine[idx]) return 27;
        return 11;
    endfunction

    function automatic void m_press(input int idx);
        if (m_ignored(idx)) return;
        if (m_mine[idx]) begin
            m_over = 1;
            for (int i = 0; i < 25; i++) if (m_mine[i]) m_stat[i] = 9;
        end else begin
            m_stat[idx] = m_nbr(idx);
            m_rev++;
            if (m_rev == 25 - m_mines) m_won = 1;
        end
    endfunction

    task automatic apply_reset(input logic [24:0] map);
        @(negedge clk);
        reset = 0; newGame = 0; pressed = 0; mineMap = map;
        @(negedge clk);
        reset = 1;
        m_reset(map);
    endtask

    task automatic read_cell(input int i, output logic [31:0] v);
        loadBlock = i;
        @(negedge clk);
        v = memDataOut2;
    endtask

    // hold pressed until ack plus 'hold' cycles; report latency, pulse count
    // and the display word at the ack cycle and the cycle after.
    task automatic do_press(input int idx, input int hold, output int lat,
                            output int pulses, output logic [31:0] rd_ack,
                            output logic [31:0] rd_next);
        int k;
        VGAid = idx; pressed = 1;
        if (idx < 25) loadBlock = idx;
        lat = -1; pulses = 0; k = 0; rd_ack = '0; rd_next = '0;
        while ((lat < 0 || k < lat + hold) && k < 400) begin
            @(negedge clk); k++;
            if (pr_reset === 1'b1) begin
                pulses++;
                if (lat < 0) begin lat = k; rd_ack = memDataOut2; end
            end
        end
        pressed = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (j == 0) rd_next = memDataOut2;
            if (pr_reset === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        apply_reset(25'h0000001);
        vectors++; if (pr_reset !== 1'b0) begin miscompares++; $display("FAIL reset_pr_reset: got %0b want 0", pr_reset); end
        vectors++; if (revealedCount !== 5'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", revealedCount); end
        vectors++; if (gameOver !== 1'b0 || gameWon !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got over=%0b won=%0b want 0/0", gameOver, gameWon); end
        for (int i = 0; i < 25; i++) begin
            read_cell(i, v);
            vectors++; if (v !== 32'd10) begin miscompares++; $display("FAIL reset_cell%0d: got %0d want 10", i, v); end
        end
        read_cell(25, v);
        vectors++; if (v !== 32'd10) begin miscompares++; $display("FAIL oob_read25: got %0d want 10", v); end
        read_cell(32'h7fff_ffff, v);
        vectors++; if (v !== 32'd10) begin miscompares++; $display("FAIL oob_readbig: got %0d want 10", v); end
    endtask

    task automatic test_safe_reveal();
        int lat, pulses;
        logic [31:0] ra, rn;
        do_press(6, 0, lat, pulses, ra, rn);
        m_press(6);
        vectors++; if (lat != 11) begin miscompares++; $display("FAIL safe_latency: got %0d want 11", lat); end
        vectors++; if (pulses != 1) begin miscompares++; $display("FAIL safe_pulses: got %0d want 1", pulses); end
        vectors++; if (ra !== 32'd10) begin miscompares++; $display("FAIL collide_read: got %0d want 10", ra); end
        vectors++; if (rn !== 32'(m_stat[6])) begin miscompares++; $display("FAIL cell6_count: got %0d want %0d", rn, m_stat[6]); end
        vectors++; if (revealedCount !== 5'(m_rev)) begin miscompares++; $display("FAIL safe_revealed: got %0d want %0d", revealedCount, m_rev); end
        do_press(24, 2, lat, pulses, ra, rn);
        m_press(24);
        vectors++; if (rn !== 32'(m_stat[24])) begin miscompares++; $display("FAIL cell24_count: got %0d want %0d", rn, m_stat[24]); end
    endtask

    task automatic test_mine();
        int lat, pulses;
        logic [31:0] ra, rn, v;
        do_press(0, 0, lat, pulses, ra, rn);
        m_press(0);
        vectors++; if (lat != 27) begin miscompares++; $display("FAIL mine_latency: got %0d want 27", lat); end
        vectors++; if (gameOver !== 1'b1) begin miscompares++; $display("FAIL mine_over: got %0b want 1", gameOver); end
        do_press(12, 1, lat, pulses, ra, rn);
        m_press(12);
        vectors++; if (lat != 2 || pulses != 1) begin miscompares++; $display("FAIL post_over_ack: got lat=%0d pulses=%0d want 2/1", lat, pulses); end
        vectors++; if (gameOver !== 1'b1 || gameWon !== 1'b0) begin miscompares++; $display("FAIL over_sticky: got over=%0b won=%0b want 1/0", gameOver, gameWon); end
        vectors++; if (revealedCount !== 5'(m_rev)) begin miscompares++; $display("FAIL over_revealed: got %0d want %0d", revealedCount, m_rev); end
        for (int i = 0; i < 25; i++) begin
            read_cell(i, v);
            vectors++; if (v !== 32'(m_stat[i])) begin miscompares++; $display("FAIL mine_board%0d: got %0d want %0d", i, v, m_stat[i]); end
        end
    endtask

    task automatic test_win();
        int lat, pulses;
        logic [31:0] ra, rn;
        apply_reset(25'h1000000);
        for (int i = 0; i < 24; i++) begin
            do_press(i, 0, lat, pulses, ra, rn);
            m_press(i);
            vectors++; if (rn !== 32'(m_stat[i]) || lat != 11) begin miscompares++; $display("FAIL win_cell%0d: got %0d lat %0d want %0d lat 11", i, rn, lat, m_stat[i]); end
            vectors++; if (gameWon !== m_won) begin miscompares++; $display("FAIL win_flag%0d: got %0b want %0b", i, gameWon, m_won); end
        end
        vectors++; if (revealedCount !== 5'd24) begin miscompares++; $display("FAIL win_revealed: got %0d want 24", revealedCount); end
        do_press(24, 0, lat, pulses, ra, rn);
        m_press(24);
        vectors++; if (gameOver !== 1'b0 || gameWon !== 1'b1 || lat != 2) begin miscompares++; $display("FAIL won_then_mine: got over=%0b won=%0b lat=%0d want 0/1/2", gameOver, gameWon, lat); end
    endtask

    task automatic test_edges();
        int lat, pulses;
        logic [31:0] ra, rn, v;
        apply_reset(25'h0000020);   // mine at row1 col0, just past the row-0 end
        do_press(4, 0, lat, pulses, ra, rn);
        m_press(4);
        vectors++; if (rn !== 32'd0) begin miscompares++; $display("FAIL no_row_wrap: got %0d want 0", rn); end
        do_press(20, 0, lat, pulses, ra, rn);
        m_press(20);
        vectors++; if (rn !== 32'(m_stat[20])) begin miscompares++; $display("FAIL corner20: got %0d want %0d", rn, m_stat[20]); end
        do_press(30, 0, lat, pulses, ra, rn);
        m_press(30);
        vectors++; if (lat != 2 || pulses != 1 || revealedCount !== 5'(m_rev)) begin miscompares++; $display("FAIL oob_press: got lat=%0d pulses=%0d rev=%0d want 2/1/%0d", lat, pulses, revealedCount, m_rev); end
        for (int i = 0; i < 25; i++) begin
            read_cell(i, v);
            vectors++; if (v !== 32'(m_stat[i])) begin miscompares++; $display("FAIL edge_board%0d: got %0d want %0d", i, v, m_stat[i]); end
        end
    endtask

    task automatic test_hold();
        int lat, pulses;
        logic [31:0] ra, rn;
        apply_reset(25'h0000100);
        do_press(12, 100, lat, pulses, ra, rn);
        m_press(12);
        vectors++; if (pulses != 1) begin miscompares++; $display("FAIL hold_pulses: got %0d want 1", pulses); end
        vectors++; if (revealedCount !== 5'(m_rev)) begin miscompares++; $display("FAIL hold_revealed: got %0d want %0d", revealedCount, m_rev); end
        vectors++; if (rn !== 32'(m_stat[12])) begin miscompares++; $display("FAIL hold_cell: got %0d want %0d", rn, m_stat[12]); end
    endtask

    task automatic test_newgame_mid();
        int seen, lat, pulses;
        logic [31:0] v, ra, rn;
        apply_reset(25'h0000008);
        VGAid = 2; pressed = 1;
        repeat (5) @(negedge clk);
        newGame = 1; pressed = 0; mineMap = 25'h0001000;
        @(negedge clk);
        newGame = 0;
        m_reset(25'h0001000);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (pr_reset === 1'b1) seen++;
        end
        vectors++; if (seen != 0) begin miscompares++; $display("FAIL newgame_ack: got %0d pulses want 0", seen); end
        vectors++; if (revealedCount !== 5'd0 || gameOver !== 1'b0) begin miscompares++; $display("FAIL newgame_state: got rev=%0d over=%0b want 0/0", revealedCount, gameOver); end
        for (int i = 0; i < 25; i++) begin
            read_cell(i, v);
            vectors++; if (v !== 32'd10) begin miscompares++; $display("FAIL newgame_cell%0d: got %0d want 10", i, v); end
        end
        do_press(7, 0, lat, pulses, ra, rn);
        m_press(7);
        vectors++; if (rn !== 32'(m_stat[7])) begin miscompares++; $display("FAIL newgame_map: got %0d want %0d", rn, m_stat[7]); end
    endtask

    task automatic test_random();
        int lat, pulses, idx, hold, exp_lat;
        logic [31:0] ra, rn, v;
        logic [24:0] map;
        for (int r = 0; r < 4; r++) begin
            map = '0;
            for (int i = 0; i < 25; i++) map[i] = ($urandom_range(0, 5) == 0);
            apply_reset(map);
            for (int p = 0; p < 12; p++) begin
                idx = $urandom_range(0, 26);
                hold = $urandom_range(0, 3);
                exp_lat = m_latency(idx);
                do_press(idx, hold, lat, pulses, ra, rn);
                m_press(idx);
                vectors++; if (lat != exp_lat || pulses != 1) begin miscompares++; $display("FAIL rnd_ack r%0d idx%0d: got lat=%0d pulses=%0d want %0d/1", r, idx, lat, pulses, exp_lat); end
                vectors++; if (revealedCount !== 5'(m_rev) || gameOver !== m_over || gameWon !== m_won) begin
                    miscompares++; $display("FAIL rnd_state r%0d idx%0d: got rev=%0d over=%0b won=%0b want %0d/%0b/%0b", r, idx, revealedCount, gameOver, gameWon, m_rev, m_over, m_won);
                end
            end
            for (int i = 0; i < 25; i++) begin
                read_cell(i, v);
                vectors++; if (v !== 32'(m_stat[i])) begin miscompares++; $display("FAIL rnd_board r%0d cell%0d: got %0d want %0d", r, i, v, m_stat[i]); end
            end
        end
    endtask

`ifdef BOARD_FLAG_EN
    task automatic do_flag(input int idx, output int lat);
        int k;
        VGAid = idx; flagReq = 1; lat = -1; k = 0;
        while (lat < 0 && k < 100) begin
            @(negedge clk); k++;
            if (pr_reset === 1'b1) lat = k;
        end
        flagReq = 0;
        repeat (3) @(negedge clk);
        if (idx < 25) begin
            if (m_stat[idx] == 10) m_stat[idx] = 11;
            else if (m_stat[idx] == 11) m_stat[idx] = 10;
        end
    endtask

    task automatic test_flag();
        int lat, pulses;
        logic [31:0] v, ra, rn;
        apply_reset(25'h0000001);
        do_flag(3, lat);
        read_cell(3, v);
        vectors++; if (v !== 32'd11 || lat != 1) begin miscompares++; $display("FAIL flag_set: got %0d lat %0d want 11 lat 1", v, lat); end
        do_press(3, 0, lat, pulses, ra, rn);
        m_press(3);
        vectors++; if (rn !== 32'd11 || lat != 2 || revealedCount !== 5'd0) begin miscompares++; $display("FAIL flag_blocks_reveal: got %0d lat %0d rev %0d want 11/2/0", rn, lat, revealedCount); end
        do_flag(3, lat);
        read_cell(3, v);
        vectors++; if (v !== 32'd10) begin miscompares++; $display("FAIL flag_clear: got %0d want 10", v); end
    endtask
`endif

    initial begin
        reset = 0; newGame = 0; pressed = 0; mineMap = '0; loadBlock = '0; VGAid = '0;
`ifdef BOARD_FLAG_EN
        flagReq = 0;
`endif
        test_reset();
        test_safe_reveal();
        test_mine();
        test_win();
        test_edges();
        test_hold();
        test_newgame_mid();
        test_random();
`ifdef BOARD_FLAG_EN
        test_flag();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
